// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl
//   GPIO pad bank between the core GPIO signals and the top-level inout pins.
//   Registered push-pull / open-drain drive, a multi-flop input synchroniser,
//   a per-pin debounce filter, and rising/falling edge capture into sticky
//   pending bits that are ORed into one interrupt line.
//
// Ports
//   clk_i          bank clock
//   rst_i          synchronous active-high reset
//   pad_io         top-level pins (WIDTH)
//   out_i          drive value from core (WIDTH)
//   oe_i           output enable, 1 = drive (WIDTH)
//   od_i           open-drain select, 1 = open-drain (WIDTH)
//   in_o           synchronised, debounced pin value (WIDTH)
//   debounce_len_i stable cycles required before in_o follows; 0 = bypass
//   rise_en_i      rising-edge capture enable (WIDTH)
//   fall_en_i      falling-edge capture enable (WIDTH)
//   irq_clr_i      pending clear, level, acts every asserted cycle (WIDTH)
//   irq_pend_o     sticky pending edge flags (WIDTH)
//   irq_o          OR of irq_pend_o
//   armed_o        edge capture active after post-reset settling
module gpio_bank_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  inout  wire  [WIDTH-1:0]      pad_io,
  input  logic [WIDTH-1:0]      out_i,
  input  logic [WIDTH-1:0]      oe_i,
  input  logic [WIDTH-1:0]      od_i,
  output logic [WIDTH-1:0]      in_o,
  input  logic [DEBOUNCE_W-1:0] debounce_len_i,
  input  logic [WIDTH-1:0]      rise_en_i,
  input  logic [WIDTH-1:0]      fall_en_i,
  input  logic [WIDTH-1:0]      irq_clr_i,
  output logic [WIDTH-1:0]      irq_pend_o,
  output logic                  irq_o,
  output logic                  armed_o
);

  // Settling covers the synchroniser depth plus the longest possible
  // debounce window, so the first filtered value is never seen as an edge.
  localparam int SETTLE   = SYNC_STAGES + (1 << DEBOUNCE_W);
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  logic [WIDTH-1:0]      out_q;
  logic [WIDTH-1:0]      oe_q;
  logic [WIDTH-1:0]      od_q;
  logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
  logic [DEBOUNCE_W-1:0] cnt    [WIDTH];
  logic [WIDTH-1:0]      filt;
  logic [WIDTH-1:0]      filt_d;
  logic [WIDTH-1:0]      pend;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  armed;

  logic [WIDTH-1:0]      drv_en;
  logic [WIDTH-1:0]      s;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      fall;

  // One debounce step for a single pin: returns {filt_next, cnt_next}.
  // The compare is done one bit wider so cnt+1 cannot wrap, and >= lets a
  // shortened length commit on the next differing edge.
  function automatic logic [DEBOUNCE_W:0] deb_step(
    input logic                  s_bit,
    input logic                  f_bit,
    input logic [DEBOUNCE_W-1:0] c,
    input logic [DEBOUNCE_W-1:0] len
  );
    logic [DEBOUNCE_W:0] nxt;
    nxt = {1'b0, c} + {{DEBOUNCE_W{1'b0}}, 1'b1};
    if (len == '0)
      return {s_bit, {DEBOUNCE_W{1'b0}}};
    else if (s_bit == f_bit)
      return {f_bit, {DEBOUNCE_W{1'b0}}};
    else if (nxt >= {1'b0, len})
      return {s_bit, {DEBOUNCE_W{1'b0}}};
    else
      return {f_bit, nxt[DEBOUNCE_W-1:0]};
  endfunction

  // Drive registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
      oe_q  <= '0;
      od_q  <= '0;
    end else begin
      out_q <= out_i;
      oe_q  <= oe_i;
      od_q  <= od_i;
    end
  end

  // In open-drain mode the pad is only driven while the value is 0, so the
  // driven value is out_q in both modes; only the enable differs.
  assign drv_en = oe_q & (~od_q | ~out_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad_io[i] = drv_en[i] ? out_q[i] : 1'bz;
  end

  // Synchroniser
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_io;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce filter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        logic [DEBOUNCE_W:0] r;
        r = deb_step(s[i], filt[i], cnt[i], debounce_len_i);
        filt[i] <= r[DEBOUNCE_W];
        cnt[i]  <= r[DEBOUNCE_W-1:0];
      end
    end
  end

  assign in_o = filt;

  // Settling counter; armed latches until the next reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else if (!armed) begin
      settle_cnt <= settle_cnt + 1'b1;
      if (settle_cnt == SETTLE_W'(SETTLE - 1)) armed <= 1'b1;
    end
  end

  // Edge detect and sticky pending; a set in the same cycle beats a clear
  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_d <= '0;
      pend   <= '0;
    end else begin
      filt_d <= filt;
      pend   <= (pend & ~irq_clr_i)
              | ({WIDTH{armed}} & ((rise & rise_en_i) | (fall & fall_en_i)));
    end
  end

  assign irq_pend_o = pend;
  assign irq_o      = |pend;
  assign armed_o    = armed;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Testbench for gpio_bank_ctrl (WIDTH=32, SYNC_STAGES=2, DEBOUNCE_W=8).
// Every pad has a pull-up; ext_en/ext_val model an external driver per pin.
module tb_gpio_bank_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  wire  [W-1:0]  pad;
  logic [W-1:0]  out_v, oe_v, od_v;
  logic [W-1:0]  in_v;
  logic [7:0]    len;
  logic [W-1:0]  rise_en, fall_en, clr;
  logic [W-1:0]  pend;
  logic          irq, armed;
  logic [W-1:0]  ext_en, ext_val;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_ext
    pullup (pad[i]);
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  gpio_bank_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pad_io         (pad),
    .out_i          (out_v),
    .oe_i           (oe_v),
    .od_i           (od_v),
    .in_o           (in_v),
    .debounce_len_i (len),
    .rise_en_i      (rise_en),
    .fall_en_i      (fall_en),
    .irq_clr_i      (clr),
    .irq_pend_o     (pend),
    .irq_o          (irq),
    .armed_o        (armed)
  );

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    string       et;
    logic [31:0] ev;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
      return;
    end
    et = tag_q.pop_front();
    ev = val_q.pop_front();
    assert (obs === ev && et == tag) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (queued tag %s)", tag, obs, ev, et);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_v = '0; oe_v = '0; od_v = '0; len = '0;
    rise_en = 32'h0000_0080; fall_en = '0; clr = '0;
    ext_en = 32'h0000_0080; ext_val = 32'h0000_0080;

    // Reset state
    push("rst_in", 32'h0); push("rst_pend", 32'h0); push("rst_irq", 32'h0);
    push("rst_armed", 32'h0); push("rst_pad", 32'hFFFF_FFFF);
    step(1);
    check("rst_in", in_v); check("rst_pend", pend); check("rst_irq", 32'(irq));
    check("rst_armed", 32'(armed)); check("rst_pad", pad);

    // Settling: armed after 2+256 edges, pin 7 high through reset gives no pend
    rst = 1'b0;
    push("settle_pre", 32'h0);
    step(257);
    check("settle_pre", 32'(armed));
    push("settle_armed", 32'h1); push("settle_in", 32'hFFFF_FFFF); push("settle_pend", 32'h0);
    step(1);
    check("settle_armed", 32'(armed)); check("settle_in", in_v); check("settle_pend", pend);

    // Push-pull with output enable on the upper half
    out_v = 32'hA5A5_0000; oe_v = 32'hFFFF_0000;
    push("pp_pad_hi", 32'hA5A5);
    step(1);
    check("pp_pad_hi", 32'(pad[31:16]));
    push("pp_in_early", 32'hFFFF);
    step(2);
    check("pp_in_early", 32'(in_v[31:16]));
    push("pp_in_hi", 32'hA5A5);
    step(1);
    check("pp_in_hi", 32'(in_v[31:16]));
    ext_en = 32'h0000_FFFF; ext_val = 32'h0000_0080;
    push("pp_lo_z", 32'h0080);
    #1;
    check("pp_lo_z", 32'(pad[15:0]));

    // Open-drain on pin 0 with pull-up
    od_v[0] = 1'b1; oe_v[0] = 1'b1; out_v[0] = 1'b0; ext_en[0] = 1'b0;
    push("od_low", 32'h0);
    step(1);
    check("od_low", 32'(pad[0]));
    out_v[0] = 1'b1;
    push("od_release", 32'h1);
    step(1);
    check("od_release", 32'(pad[0]));
    push("od_in_high", 32'h1);
    step(3);
    check("od_in_high", 32'(in_v[0]));
    ext_en[0] = 1'b1;
    push("od_ext_low", 32'h0);
    step(3);
    check("od_ext_low", 32'(in_v[0]));

    // Edge IRQ on pin 5 (rising only)
    rise_en = 32'h0000_00A0;
    ext_val[5] = 1'b1;
    push("irq_rise_early", 32'h0);
    step(3);
    check("irq_rise_early", pend);
    push("irq_rise", 32'h20); push("irq_rise_o", 32'h1);
    step(1);
    check("irq_rise", pend); check("irq_rise_o", 32'(irq));
    ext_val[5] = 1'b0;
    push("irq_fall_ign", 32'h20);
    step(6);
    check("irq_fall_ign", pend);
    clr[5] = 1'b1; ext_val[5] = 1'b1;
    push("irq_clr_held", 32'h0);
    step(3);
    check("irq_clr_held", pend);
    push("irq_set_wins", 32'h20);
    step(1);
    check("irq_set_wins", pend);
    clr[5] = 1'b0;
    push("irq_sticky", 32'h20);
    step(2);
    check("irq_sticky", pend);
    clr[5] = 1'b1;
    push("irq_clr", 32'h0); push("irq_clr_o", 32'h0);
    step(1);
    check("irq_clr", pend); check("irq_clr_o", 32'(irq));
    clr[5] = 1'b0;

    // Debounce on pin 3, length 4
    len = 8'd4; rise_en = 32'h0000_00A8;
    step(4);
    ext_val[3] = 1'b1;
    step(3);
    ext_val[3] = 1'b0;
    push("deb_glitch_in", 32'h0); push("deb_glitch_pend", 32'h0);
    step(8);
    check("deb_glitch_in", 32'(in_v[3])); check("deb_glitch_pend", pend);
    ext_val[3] = 1'b1;
    step(4);
    ext_val[3] = 1'b0;
    push("deb_pulse_early", 32'h0);
    step(1);
    check("deb_pulse_early", 32'(in_v[3]));
    push("deb_pulse_commit", 32'h1);
    step(1);
    check("deb_pulse_commit", 32'(in_v[3]));
    push("deb_pulse_pend", 32'h08);
    step(1);
    check("deb_pulse_pend", pend);
    clr[3] = 1'b1;
    push("deb_pend_clr", 32'h0);
    step(1);
    check("deb_pend_clr", pend);
    clr[3] = 1'b0;
    push("deb_fall", 32'h0);
    step(6);
    check("deb_fall", 32'(in_v[3]));

    // Lower debounce length mid-count
    rise_en = 32'h0000_00A0; len = 8'd200;
    ext_val[3] = 1'b1;
    push("deb_long_hold", 32'h0);
    step(10);
    check("deb_long_hold", 32'(in_v[3]));
    len = 8'd2;
    push("deb_len_drop", 32'h1);
    step(1);
    check("deb_len_drop", 32'(in_v[3]));

    // Build pend = 0x21, drive all pads, then reset mid-operation
    ext_val[5] = 1'b0;
    step(10);
    rise_en = 32'h0000_00A1; ext_en[0] = 1'b0; ext_val[5] = 1'b1;
    push("mid_pend_early", 32'h0);
    step(4);
    check("mid_pend_early", pend);
    push("mid_pend", 32'h21); push("mid_irq", 32'h1);
    step(1);
    check("mid_pend", pend); check("mid_irq", 32'(irq));
    ext_en = '0; out_v = '0; oe_v = 32'hFFFF_FFFF; od_v = '0;
    push("mid_pad_drv", 32'h0); push("mid_pend_keep", 32'h21);
    step(1);
    check("mid_pad_drv", pad); check("mid_pend_keep", pend);
    rst = 1'b1;
    push("mr_pad", 32'hFFFF_FFFF); push("mr_pend", 32'h0); push("mr_irq", 32'h0);
    push("mr_in", 32'h0); push("mr_armed", 32'h0);
    step(1);
    check("mr_pad", pad); check("mr_pend", pend); check("mr_irq", 32'(irq));
    check("mr_in", in_v); check("mr_armed", 32'(armed));
    rst = 1'b0;
    push("mr_pad_after", 32'h0); push("mr_armed_after", 32'h0);
    step(1);
    check("mr_pad_after", pad); check("mr_armed_after", 32'(armed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
Parametrised GPIO pad bank placed between the SoC GPIO outputs and the top-level inout pins. It replaces the per-bit tristate assigns with a single configurable block. Features:
- Registered push-pull or open-drain pad drive.
- Multi-stage input synchroniser.
- Per-pin programmable debounce filter.
- Per-pin rising/falling edge capture into sticky pending bits, ORed into one interrupt line for the core.

Parameters:
- WIDTH, 32, number of pins in the bank.
- SYNC_STAGES, 2, input synchroniser flops per pin (≥2).
- DEBOUNCE_W, 8, width of each per-pin debounce counter and of debounce_len_i.

Ports:
- clk_i  in  1  bank clock (SoC system clock).
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- pad_io  inout  WIDTH  top-level pins.
- out_i  in  WIDTH  drive value from core.
- oe_i  in  WIDTH  output enable from core, 1 = drive.
- od_i  in  WIDTH  per-pin open-drain select, 1 = open-drain.
- in_o  out  WIDTH  synchronised, debounced pin value to core.
- debounce_len_i  in  DEBOUNCE_W  stable cycles required; 0 = bypass.
- rise_en_i  in  WIDTH  per-pin rising-edge capture enable.
- fall_en_i  in  WIDTH  per-pin falling-edge capture enable.
- irq_clr_i  in  WIDTH  per-pin pending clear (level, acts every cycle asserted).
- irq_pend_o  out  WIDTH  sticky pending edge flags.
- irq_o  out  1  OR of irq_pend_o.
- armed_o  out  1  edge detection active after post-reset settling.

Behaviour:
- **Reset values:** all registers (out_q, oe_q, od_q, sync chain, cnt, filt, filt_d, pend, settle counter, armed) = 0. Consequently in_o = 0, irq_pend_o = 0, irq_o = 0, armed_o = 0, and every pad is Z during reset and on the first cycle after it.
- **Drive path:**
  - out_i/oe_i/od_i are registered into out_q/oe_q/od_q, giving 1 cycle latency from input change to pad change.
  - Push-pull (od_q = 0): pad = oe_q ? out_q : Z.
  - Open-drain (od_q = 1): pad = (oe_q & ~out_q) ? 0 : Z.
- **Synchroniser:** pad value passes through SYNC_STAGES flops; s = last stage. A pad change appears on s after SYNC_STAGES edges. Pins driven by the bank read back their own drive through this path.
- **Debounce, per pin:**
  - debounce_len_i = 0: filt <= s every cycle (1 edge latency).
  - Otherwise, if s == filt: cnt <= 0.
  - Otherwise, if cnt+1 >= debounce_len_i: filt <= s and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Net effect: filt follows s only after s has differed for debounce_len_i consecutive edges. A glitch shorter than that resets cnt and never reaches filt.
  - The >= compare means lowering debounce_len_i mid-count commits on the next differing edge; no counter wrap is possible.
- **Output:** in_o = filt.
- **Settling:**
  - A settle counter runs from reset release; armed is set after SYNC_STAGES + 2^DEBOUNCE_W edges and stays set until rst_i.
  - While armed = 0, filt_d tracks filt but no edges are captured. This suppresses the reset-to-pin-level pseudo-edge.
- **Edge detect:** filt_d <= filt each cycle. rise = filt & ~filt_d; fall = ~filt & filt_d.
- **Pending:** pend <= (pend & ~irq_clr_i) | (armed & ((rise & rise_en_i) | (fall & fall_en_i))).
  - Set wins over a clear in the same cycle.
  - Enables gate capture only; clearing an enable does not clear existing pend bits.
  - Clear has no effect on bits not being set.
- **Interrupt:** irq_o = |pend, derived from registered pend with no extra latency.
- **Total latency** from pad edge to pend (len = L ≥ 1, armed): SYNC_STAGES + L + 1 edges to pend set. irq_o rises in the same cycle as pend.
- **rst_i mid-operation:** all state returns to reset values on the next edge. Pending bits are lost, pads go Z, and re-arming requires the full settle period again.

Test Plan:
1. Push-pull/OE: WIDTH = 32. out_i = 0xA5A5_0000, oe_i = 0xFFFF_0000, od_i = 0 → one cycle later pad[31:16] = 0xA5A5 and pad[15:0] = Z. With 2 sync stages and len = 0, in_o[31:16] = 0xA5A5 three edges after the pad change.
2. Open-drain: od_i[0] = 1, oe_i[0] = 1, external pull-up. out_i[0] = 0 → pad[0] = 0. out_i[0] = 1 → pad[0] = Z, reads 1. External driver pulls low while out_i[0] = 1 → in_o[0] = 0.
3. Debounce: len = 4; pin 3 idle 0.
   - High pulses of 3 cycles → in_o[3] stays 0 and pend[3] stays 0.
   - 4-cycle pulse → in_o[3] = 1 exactly SYNC_STAGES + 4 edges after the pad rise.
   - Drop len 200→2 mid-count → commit on the next edge.
4. Edge IRQ: armed; rise_en[5] = 1, fall_en[5] = 0.
   - 0→1 → pend[5] = 1, irq_o = 1.
   - 1→0 → no change.
   - irq_clr[5] held in the same cycle as a new rise → pend[5] stays 1.
   - Clear alone → pend = 0, irq_o = 0.
5. Settling: pad[7] held high through reset with rise_en[7] = 1 → in_o[7] = 1 after settling but pend[7] = 0. armed_o rises at exactly SYNC_STAGES + 256 edges after reset release (DEBOUNCE_W = 8).
6. Reset mid-operation: pend = 0x0000_0021, oe_q = 0xFFFF_FFFF, then assert rst_i for one cycle → next edge: all pads Z, pend = 0, irq_o = 0, in_o = 0, armed_o = 0.
